mjpg_frame_ctrl: RTL and testbench



---
 rtl/mjpg_pkg.sv | 26 ++
 rtl/mjpg_frame_ctrl_meas.sv | 89 ++++++++
 rtl/mjpg_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mjpg_frame_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mjpg_pkg.sv
// Shared types and constants for the MJPG front-end frame controller.
package mjpg_pkg;

    localparam int unsigned DIM_W       = 12;
    localparam int unsigned DEF_W_ALIGN = 16;
    localparam int unsigned DEF_H_ALIGN = 8;

    typedef logic [DIM_W-1:0] dim_t;

    localparam dim_t DIM_MAX = '1;

    typedef enum logic [2:0] {
        StSync,
        StMeas,
        StConfig,
        StArmed,
        StRun
    } ctrl_state_e;

    // Nonzero, within the limit, and a whole number of MCUs.
    function automatic logic dim_ok(input dim_t d, input int unsigned max_d,
                                    input int unsigned align);
        return (d != '0) && (32'(d) <= max_d) && ((32'(d) % align) == 32'd0);
    endfunction

endpackage

// File: rtl/mjpg_frame_ctrl_meas.sv
// Resolution measurement: sync edge detection, pixel/line counters and per-frame conformance.
module vid_meas
    import mjpg_pkg::*;
#(
    parameter int unsigned MAX_W   = 1920,
    parameter int unsigned MAX_H   = 1080,
    parameter int unsigned W_ALIGN = DEF_W_ALIGN,
    parameter int unsigned H_ALIGN = DEF_H_ALIGN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pvalid,
    input  logic             hsync,
    input  logic             vsync,
    output logic             line_done,
    output logic [DIM_W-1:0] line_pix,
    output logic [DIM_W-1:0] line_num,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [DIM_W-1:0] frame_w,
    output logic [DIM_W-1:0] frame_h
);

    logic hs_q, vs_q, bad_q, seen_q;
    dim_t pix_q, lines_q, ref_w_q;

    logic hs_rise, vs_rise, first_line, bad_d;
    dim_t ref_w_d, lines_d;

    // Frame results include a line closing on the same cycle as the vsync edge.
    always_comb begin
        hs_rise    = hsync & ~hs_q;
        vs_rise    = vsync & ~vs_q;
        line_done  = (hs_rise | vs_rise) && (pix_q != '0);
        line_pix   = pix_q;
        line_num   = (lines_q == DIM_MAX) ? lines_q : lines_q + dim_t'(1);
        first_line = (lines_q == '0);
        ref_w_d    = ref_w_q;
        bad_d      = bad_q;
        lines_d    = lines_q;
        if (line_done) begin
            if (first_line) begin
                ref_w_d = pix_q;
            end else if (pix_q != ref_w_q) begin
                bad_d = 1'b1;
            end
            if (pix_q == DIM_MAX) begin
                bad_d = 1'b1;
            end
            lines_d = line_num;
        end
        frame_done = vs_rise;
        frame_w    = ref_w_d;
        frame_h    = lines_d;
        frame_ok   = seen_q && !bad_d && dim_ok(ref_w_d, MAX_W, W_ALIGN)
                     && dim_ok(lines_d, MAX_H, H_ALIGN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            bad_q   <= 1'b0;
            seen_q  <= 1'b0;
            pix_q   <= '0;
            lines_q <= '0;
            ref_w_q <= '0;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            if (line_done) begin
                pix_q <= dim_t'(pvalid);
            end else if (pvalid && (pix_q != DIM_MAX)) begin
                pix_q <= pix_q + dim_t'(1);
            end
            if (vs_rise) begin
                lines_q <= '0;
                ref_w_q <= '0;
                bad_q   <= 1'b0;
                seen_q  <= 1'b1;
            end else begin
                lines_q <= lines_d;
                ref_w_q <= ref_w_d;
                bad_q   <= bad_d;
            end
        end
    end

endmodule

// File: rtl/mjpg_frame_ctrl.sv
// Front-end sequencer for MJPG_ENCODER: locks onto a stable MCU-aligned resolution,
// programs the encoder and gates pixels through on whole conforming frames only.
module mjpg_frame_ctrl
    import mjpg_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned MAX_W       = 1920,
    parameter int unsigned MAX_H       = 1080,
    parameter int unsigned W_ALIGN     = DEF_W_ALIGN,
    parameter int unsigned H_ALIGN     = DEF_H_ALIGN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pvalid,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [23:0]      in_ycbcr,
    output logic             out_pvalid,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic [23:0]      out_ycbcr,
    output logic             cfg_we,
    output logic [DIM_W-1:0] cfg_width,
    output logic [DIM_W-1:0] cfg_height,
    output logic             locked,
    output logic             frame_start,
    output logic             frame_abort,
    output logic [15:0]      abort_cnt
);

    ctrl_state_e state_q;
    logic        pv_q, hs_q, vs_q, gate_q;
    logic [23:0] ycbcr_q;
    logic        cfg_we_q, start_q, abort_q;
    dim_t        cfg_w_q, cfg_h_q, cand_w_q, cand_h_q;
    logic [7:0]  stable_q;
    logic [15:0] abort_cnt_q;

    logic line_done, frame_done, frame_ok;
    dim_t line_pix, line_num, frame_w, frame_h;

    vid_meas #(
        .MAX_W  (MAX_W),
        .MAX_H  (MAX_H),
        .W_ALIGN(W_ALIGN),
        .H_ALIGN(H_ALIGN)
    ) u_meas (
        .clk       (clk),
        .rst       (rst),
        .pvalid    (in_pvalid),
        .hsync     (in_hsync),
        .vsync     (in_vsync),
        .line_done (line_done),
        .line_pix  (line_pix),
        .line_num  (line_num),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .frame_w   (frame_w),
        .frame_h   (frame_h)
    );

    logic       cfg_match, cand_match, line_viol, lock_hit;
    logic [7:0] stable_inc;

    always_comb begin
        cfg_match  = (frame_w == cfg_w_q) && (frame_h == cfg_h_q);
        cand_match = (frame_w == cand_w_q) && (frame_h == cand_h_q);
        line_viol  = line_done && ((line_pix != cfg_w_q) || (line_num > cfg_h_q));
        stable_inc = stable_q + 8'd1;
        lock_hit   = 32'(stable_inc) >= LOCK_FRAMES;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ycbcr_q <= '0;
        end else begin
            pv_q    <= in_pvalid;
            hs_q    <= in_hsync;
            vs_q    <= in_vsync;
            ycbcr_q <= in_ycbcr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSync;
            gate_q      <= 1'b0;
            cfg_we_q    <= 1'b0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            cand_w_q    <= '0;
            cand_h_q    <= '0;
            stable_q    <= '0;
            abort_cnt_q <= '0;
        end else begin
            cfg_we_q <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            case (state_q)
                StSync: begin
                    if (frame_done) begin
                        state_q <= StMeas;
                    end
                end
                StMeas: begin
                    if (frame_done) begin
                        if (!frame_ok) begin
                            stable_q <= '0;
                        end else if (cand_match) begin
                            stable_q <= stable_inc;
                            if (lock_hit) begin
                                state_q <= StConfig;
                            end
                        end else begin
                            cand_w_q <= frame_w;
                            cand_h_q <= frame_h;
                            stable_q <= 8'd1;
                            if (LOCK_FRAMES <= 1) begin
                                state_q <= StConfig;
                            end
                        end
                    end
                end
                StConfig: begin
                    cfg_w_q  <= cand_w_q;
                    cfg_h_q  <= cand_h_q;
                    cfg_we_q <= 1'b1;
                    state_q  <= StArmed;
                end
                StArmed: begin
                    if (frame_done) begin
                        if (frame_ok && cfg_match) begin
                            state_q <= StRun;
                            gate_q  <= 1'b1;
                            start_q <= 1'b1;
                        end else begin
                            state_q  <= StMeas;
                            stable_q <= '0;
                        end
                    end
                end
                StRun: begin
                    // A bad line and a bad frame close on the same cycle count as one abort.
                    if (line_viol || (frame_done && !(frame_ok && cfg_match))) begin
                        state_q  <= StMeas;
                        gate_q   <= 1'b0;
                        stable_q <= '0;
                        abort_q  <= 1'b1;
                        if (abort_cnt_q != 16'hFFFF) begin
                            abort_cnt_q <= abort_cnt_q + 16'd1;
                        end
                    end else if (frame_done) begin
                        start_q <= 1'b1;
                    end
                end
                default: state_q <= StSync;
            endcase
        end
    end

    assign out_pvalid  = pv_q & gate_q;
    assign out_hsync   = hs_q;
    assign out_vsync   = vs_q;
    assign out_ycbcr   = ycbcr_q;
    assign cfg_we      = cfg_we_q;
    assign cfg_width   = cfg_w_q;
    assign cfg_height  = cfg_h_q;
    assign locked      = (state_q == StArmed) || (state_q == StRun);
    assign frame_start = start_q;
    assign frame_abort = abort_q;
    assign abort_cnt   = abort_cnt_q;

endmodule

// File: tb/tb_mjpg_frame_ctrl.sv
// Directed bench for mjpg_frame_ctrl: a per-frame vector table plus reset and latency sequences.
module tb_mjpg_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_pvalid, in_hsync, in_vsync;
    logic [23:0] in_ycbcr;
    logic        out_pvalid, out_hsync, out_vsync;
    logic [23:0] out_ycbcr;
    logic        cfg_we;
    logic [11:0] cfg_width, cfg_height;
    logic        locked, frame_start, frame_abort;
    logic [15:0] abort_cnt;

    always #5 clk = ~clk;

    mjpg_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_pvalid  (in_pvalid),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_ycbcr   (in_ycbcr),
        .out_pvalid (out_pvalid),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_ycbcr  (out_ycbcr),
        .cfg_we     (cfg_we),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .locked     (locked),
        .frame_start(frame_start),
        .frame_abort(frame_abort),
        .abort_cnt  (abort_cnt)
    );

    // One record per frame: geometry in, per-frame event counts and end-of-frame state out.
    typedef struct {
        int w;
        int h;
        int bad_idx;
        int bad_w;
        int pv;
        int we;
        int st;
        int ab;
        int lk;
        int abc;
        int cw;
        int ch;
    } vec_t;

    int   n_checks = 0;
    int   n_err = 0;
    int   tot_pv = 0;
    int   tot_we = 0;
    int   tot_st = 0;
    int   tot_ab = 0;
    int   bad_start = 0;
    logic prev_vs = 1'b0;

    always @(negedge clk) begin
        if (out_pvalid)  tot_pv <= tot_pv + 1;
        if (cfg_we)      tot_we <= tot_we + 1;
        if (frame_start) tot_st <= tot_st + 1;
        if (frame_abort) tot_ab <= tot_ab + 1;
        if (frame_start && !(out_vsync && !prev_vs)) bad_start <= bad_start + 1;
        prev_vs <= out_vsync;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic pv, input logic hs, input logic vs);
        @(negedge clk);
        in_pvalid = pv;
        in_hsync  = hs;
        in_vsync  = vs;
        in_ycbcr  = pv ? 24'($urandom) : 24'h0;
    endtask

    task automatic send_frame(input int w, input int h, input int bad_idx, input int bad_w);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < ((l == bad_idx) ? bad_w : w); p++) cyc(1'b1, 1'b0, 1'b0);
            repeat (2) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input int w, input int h, input int bi, input int bw,
                                input int pv, input int we, input int st, input int ab,
                                input int lk, input int abc, input int cw, input int ch);
        vec_t v;
        v.w = w; v.h = h; v.bad_idx = bi; v.bad_w = bw;
        v.pv = pv; v.we = we; v.st = st; v.ab = ab;
        v.lk = lk; v.abc = abc; v.cw = cw; v.ch = ch;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int pv0, we0, st0, ab0;
        @(posedge clk);
        #1;
        pv0 = tot_pv; we0 = tot_we; st0 = tot_st; ab0 = tot_ab;
        send_frame(v.w, v.h, v.bad_idx, v.bad_w);
        @(posedge clk);
        #1;
        check({tag, " out_pvalid count"}, tot_pv - pv0, v.pv);
        check({tag, " cfg_we count"}, tot_we - we0, v.we);
        check({tag, " frame_start count"}, tot_st - st0, v.st);
        check({tag, " frame_abort count"}, tot_ab - ab0, v.ab);
        check({tag, " locked"}, int'(locked), v.lk);
        check({tag, " abort_cnt"}, int'(abort_cnt), v.abc);
        check({tag, " cfg_width"}, int'(cfg_width), v.cw);
        check({tag, " cfg_height"}, int'(cfg_height), v.ch);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_pvalid"}, int'(out_pvalid), 0);
        check({tag, " out_hsync"}, int'(out_hsync), 0);
        check({tag, " out_vsync"}, int'(out_vsync), 0);
        check({tag, " out_ycbcr"}, int'(out_ycbcr), 0);
        check({tag, " cfg_we"}, int'(cfg_we), 0);
        check({tag, " cfg_width"}, int'(cfg_width), 0);
        check({tag, " cfg_height"}, int'(cfg_height), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " frame_start"}, int'(frame_start), 0);
        check({tag, " frame_abort"}, int'(frame_abort), 0);
        check({tag, " abort_cnt"}, int'(abort_cnt), 0);
    endtask

    vec_t va[21];
    vec_t vb[11];

    initial begin
        rst = 1'b1; in_pvalid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_ycbcr = '0;

        // Scaled-down stream: 32x16 stands in for 640x360, 64x32 for 1280x720.
        //          w   h  bad bw   pv   we st ab lk abc  cw  ch
        va[0]  = mk(32,  3, -1, 0,    0, 0, 0, 0, 0, 0,  0,  0);
        va[1]  = mk(32, 16, -1, 0,    0, 0, 0, 0, 0, 0,  0,  0);
        va[2]  = mk(32, 16, -1, 0,    0, 1, 0, 0, 1, 0, 32, 16);
        va[3]  = mk(32, 16, -1, 0,    0, 0, 1, 0, 1, 0, 32, 16);
        va[4]  = mk(32, 16, -1, 0,  512, 0, 1, 0, 1, 0, 32, 16);
        va[5]  = mk(32, 16,  2, 24,  88, 0, 0, 1, 0, 1, 32, 16);
        va[6]  = mk(32, 16, -1, 0,    0, 0, 0, 0, 0, 1, 32, 16);
        va[7]  = mk(32, 16, -1, 0,    0, 1, 0, 0, 1, 1, 32, 16);
        va[8]  = mk(32, 16, -1, 0,    0, 0, 1, 0, 1, 1, 32, 16);
        va[9]  = mk(32, 16, -1, 0,  512, 0, 1, 0, 1, 1, 32, 16);
        va[10] = mk(64, 32, -1, 0,   64, 0, 0, 1, 0, 2, 32, 16);
        va[11] = mk(64, 32, -1, 0,    0, 1, 0, 0, 1, 2, 64, 32);
        va[12] = mk(64, 32, -1, 0,    0, 0, 1, 0, 1, 2, 64, 32);
        va[13] = mk(64, 32, -1, 0, 2048, 0, 1, 0, 1, 2, 64, 32);
        va[14] = mk(32, 16, -1, 0,   32, 0, 0, 1, 0, 3, 64, 32);
        va[15] = mk(32, 16, -1, 0,    0, 1, 0, 0, 1, 3, 32, 16);
        va[16] = mk(32,  8, -1, 0,    0, 0, 0, 0, 0, 3, 32, 16);
        va[17] = mk(32, 16, -1, 0,    0, 0, 0, 0, 0, 3, 32, 16);
        va[18] = mk(32, 16, -1, 0,    0, 1, 0, 0, 1, 3, 32, 16);
        va[19] = mk(32, 16, -1, 0,    0, 0, 1, 0, 1, 3, 32, 16);
        va[20] = mk(32, 16, -1, 0,  512, 0, 1, 0, 1, 3, 32, 16);

        // After the mid-RUN reset: unaligned 33-wide stream, then relock on 32x16.
        vb[0]  = mk(32,  3, -1, 0,    0, 0, 0, 0, 0, 0,  0,  0);
        for (int i = 1; i <= 6; i++) vb[i] = mk(33, 16, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vb[7]  = mk(32, 16, -1, 0,    0, 0, 0, 0, 0, 0,  0,  0);
        vb[8]  = mk(32, 16, -1, 0,    0, 1, 0, 0, 1, 0, 32, 16);
        vb[9]  = mk(32, 16, -1, 0,    0, 0, 1, 0, 1, 0, 32, 16);
        vb[10] = mk(32, 16, -1, 0,  512, 0, 1, 0, 1, 0, 32, 16);

        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");

        // One-cycle video path latency, forwarded even while not locked.
        @(negedge clk);
        rst = 1'b0; in_ycbcr = 24'hABCDEF; in_hsync = 1'b1; in_vsync = 1'b1;
        @(posedge clk);
        #1;
        check("latency out_ycbcr", int'(out_ycbcr), 32'hABCDEF);
        check("latency out_hsync", int'(out_hsync), 1);
        check("latency out_vsync", int'(out_vsync), 1);
        check("latency out_pvalid gated", int'(out_pvalid), 0);
        @(negedge clk);
        in_ycbcr = '0; in_hsync = 1'b0; in_vsync = 1'b0;
        @(posedge clk);
        #1;
        check("latency out_hsync low", int'(out_hsync), 0);

        for (int i = 0; i < 21; i++) run_vec(va[i], $sformatf("A%0d", i));

        // Reset in the middle of a forwarded line.
        @(negedge clk);
        in_pvalid = 1'b1; in_ycbcr = 24'h123456;
        @(posedge clk);
        #1;
        check("midrun out_pvalid before rst", int'(out_pvalid), 1);
        check("midrun locked before rst", int'(locked), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrun rst");
        @(negedge clk);
        rst = 1'b0; in_pvalid = 1'b0; in_ycbcr = '0;

        for (int i = 0; i < 11; i++) run_vec(vb[i], $sformatf("B%0d", i));

        check("frame_start aligned with out_vsync edge", bad_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
